// File: rtl/video_cap_win.sv
// video_cap_win: camera capture front end. Oversamples the sensor pixel
// clock, syncs and bus on clk, packs BPP beats per pixel and writes the
// pixels inside a programmable crop window to the SDRAM write FIFO.
module video_cap_win #(
    parameter int DW      = 8,
    parameter int BPP     = 2,
    parameter int X_START = 0,
    parameter int WIN_W   = 640,
    parameter int Y_START = 0,
    parameter int WIN_H   = 480,
    parameter int CNT_W   = 12,
    parameter int VS_POL  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              vpclk,
    input  logic              vvsync,
    input  logic              vhref,
    input  logic [DW-1:0]     vdb,
    input  logic              cap_en,
    input  logic              err_clr,
    input  logic              wrf_full,
    output logic [DW*BPP-1:0] wrf_din,
    output logic              wrf_wrreq,
    output logic              frame_start,
    output logic              frame_done,
    output logic              ovf_err
);

    localparam int PW = DW * BPP;
    localparam int BW = (BPP > 1) ? $clog2(BPP) : 1;
    localparam logic [BW-1:0]  BEAT_LAST = BW'(BPP - 1);
    localparam logic [CNT_W:0] X_LO = (CNT_W + 1)'(X_START);
    localparam logic [CNT_W:0] X_HI = (CNT_W + 1)'(X_START + WIN_W);
    localparam logic [CNT_W:0] Y_LO = (CNT_W + 1)'(Y_START);
    localparam logic [CNT_W:0] Y_HI = (CNT_W + 1)'(Y_START + WIN_H);
    localparam logic           VS_ACT = VS_POL[0];

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WAIT_VS = 2'd1;
    localparam logic [1:0] S_ACTIVE  = 2'd2;

    logic [2:0]       pclk_s;
    logic [1:0]       vs_s;
    logic [1:0]       hr_s;
    logic             vs_h;     // vsync active flag at the previous SE
    logic             hr_h;     // href at the previous SE
    logic [DW-1:0]    vdb_d1;
    logic [DW-1:0]    vdb_d2;

    logic [1:0]       state;
    logic [CNT_W-1:0] x;
    logic [CNT_W-1:0] y;
    logic [BW-1:0]    beat;
    logic [PW-1:0]    pack;

    logic             se;
    logic             vs_act;
    logic             hr;
    logic             vs_end;
    logic             vs_begin;
    logic             line_end;
    logic             take;
    logic             pix_done;
    logic             in_win;
    logic [PW-1:0]    pack_nxt;
    logic [CNT_W-1:0] x_inc;
    logic [CNT_W-1:0] y_inc;

    // Synchronise the sensor controls and delay data to stay aligned with them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pclk_s <= '0;
            vs_s   <= '0;
            hr_s   <= '0;
            vdb_d1 <= '0;
            vdb_d2 <= '0;
        end else begin
            pclk_s <= {pclk_s[1:0], vpclk};
            vs_s   <= {vs_s[0], vvsync};
            hr_s   <= {hr_s[0], vhref};
            vdb_d1 <= vdb;
            vdb_d2 <= vdb_d1;
        end
    end

    // Sample-event decode, window test and next-value helpers
    always_comb begin
        se       = pclk_s[1] & ~pclk_s[2];
        vs_act   = (vs_s[1] == VS_ACT);
        hr       = hr_s[1];
        vs_end   = se & vs_h & ~vs_act;
        vs_begin = se & ~vs_h & vs_act;
        line_end = se & hr_h & ~hr;
        take     = se & hr & (state == S_ACTIVE);
        pix_done = take & (beat == BEAT_LAST);
        in_win   = ({1'b0, x} >= X_LO) && ({1'b0, x} < X_HI) &&
                   ({1'b0, y} >= Y_LO) && ({1'b0, y} < Y_HI);
        pack_nxt = (pack << DW) | PW'(vdb_d2);
        x_inc    = (x == '1) ? x : x + 1'b1;
        y_inc    = (y == '1) ? y : y + 1'b1;
    end

    // Frame FSM, pixel/line counters, packing and FIFO write path
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            vs_h        <= 1'b0;
            hr_h        <= 1'b0;
            x           <= '0;
            y           <= '0;
            beat        <= '0;
            pack        <= '0;
            wrf_din     <= '0;
            wrf_wrreq   <= 1'b0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            ovf_err     <= 1'b0;
        end else begin
            wrf_wrreq   <= 1'b0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;

            if (se) begin
                vs_h <= vs_act;
                hr_h <= hr;
            end

            case (state)
                S_IDLE: begin
                    if (cap_en) state <= S_WAIT_VS;
                end
                S_WAIT_VS: begin
                    if (!cap_en) begin
                        state <= S_IDLE;
                    end else if (vs_end) begin
                        state       <= S_ACTIVE;
                        frame_start <= 1'b1;
                    end
                end
                S_ACTIVE: begin
                    if (vs_begin) begin
                        frame_done <= 1'b1;
                        state      <= cap_en ? S_WAIT_VS : S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase

            // Counter clear on frame start is exclusive with take/line_end,
            // both of which require ACTIVE.
            if (state == S_WAIT_VS && cap_en && vs_end) begin
                x    <= '0;
                y    <= '0;
                beat <= '0;
            end else if (take) begin
                pack <= pack_nxt;
                if (beat == BEAT_LAST) begin
                    beat <= '0;
                    x    <= x_inc;
                end else begin
                    beat <= beat + 1'b1;
                end
            end else if (state == S_ACTIVE && line_end) begin
                y    <= y_inc;
                x    <= '0;
                beat <= '0;
            end

            if (pix_done && in_win && !wrf_full) begin
                wrf_wrreq <= 1'b1;
                wrf_din   <= pack_nxt;
            end

            if (pix_done && in_win && wrf_full) begin
                ovf_err <= 1'b1;
            end else if (err_clr) begin
                ovf_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_video_cap_win.sv
// tb_video_cap_win: drives framed sensor traffic into two instances
// (active-high and active-low vsync) and scoreboards the FIFO writes.
module tb_video_cap_win;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        vpclk;
    logic        vs_line;
    logic        vs_line_n;
    logic        vhref;
    logic [7:0]  vdb;
    logic        cap_en;
    logic        err_clr;
    logic        wrf_full;

    logic [15:0] din0, din1;
    logic        wr0, wr1, fs0, fs1, fd0, fd1, ovf0, ovf1;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] q0[$];
    logic [15:0] q1[$];
    int          wr_cnt0 = 0, wr_cnt1 = 0;
    int          fs_cnt0 = 0, fs_cnt1 = 0;
    int          fd_cnt0 = 0, fd_cnt1 = 0;
    logic [15:0] first0, first1;
    logic        prev0 = 1'b0, prev1 = 1'b0;
    bit          exp_on;

    always #5 clk = ~clk;

    assign vs_line_n = ~vs_line;

    video_cap_win #(
        .DW(8), .BPP(2), .X_START(2), .WIN_W(4), .Y_START(1), .WIN_H(2),
        .CNT_W(12), .VS_POL(1)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .vpclk(vpclk), .vvsync(vs_line),
        .vhref(vhref), .vdb(vdb), .cap_en(cap_en), .err_clr(err_clr),
        .wrf_full(wrf_full), .wrf_din(din0), .wrf_wrreq(wr0),
        .frame_start(fs0), .frame_done(fd0), .ovf_err(ovf0)
    );

    video_cap_win #(
        .DW(8), .BPP(2), .X_START(2), .WIN_W(4), .Y_START(1), .WIN_H(2),
        .CNT_W(12), .VS_POL(0)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .vpclk(vpclk), .vvsync(vs_line_n),
        .vhref(vhref), .vdb(vdb), .cap_en(cap_en), .err_clr(err_clr),
        .wrf_full(wrf_full), .wrf_din(din1), .wrf_wrreq(wr1),
        .frame_start(fs1), .frame_done(fd1), .ovf_err(ovf1)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Write monitor: pops the scoreboard on every write strobe
    always @(negedge clk) begin
        if (wr0) begin
            check("wr0_gap", 32'(prev0), 32'd0);
            if (q0.size() == 0) check("wr0_unexp", 32'(wr0), 32'd0);
            else check("wr0_data", 32'(din0), 32'(q0.pop_front()));
            if (wr_cnt0 == 0) first0 = din0;
            wr_cnt0++;
        end
        if (wr1) begin
            check("wr1_gap", 32'(prev1), 32'd0);
            if (q1.size() == 0) check("wr1_unexp", 32'(wr1), 32'd0);
            else check("wr1_data", 32'(din1), 32'(q1.pop_front()));
            if (wr_cnt1 == 0) first1 = din1;
            wr_cnt1++;
        end
        prev0 = wr0;
        prev1 = wr1;
        fs_cnt0 += int'(fs0);
        fs_cnt1 += int'(fs1);
        fd_cnt0 += int'(fd0);
        fd_cnt1 += int'(fd1);
    end

    task automatic pclk_cycle(input logic vs, input logic hr, input logic [7:0] d, input logic full);
        @(negedge clk);
        vpclk   = 1'b0;
        vs_line = vs;
        vhref   = hr;
        vdb     = d;
        @(negedge clk);
        @(negedge clk);
        vpclk    = 1'b1;
        wrf_full = full;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_wrreq0", 32'(wr0), 32'd0);
        check("rst_wrreq1", 32'(wr1), 32'd0);
        check("rst_din0", 32'(din0), 32'd0);
        check("rst_din1", 32'(din1), 32'd0);
        exp_on = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One frame: vs low lead-in, 4 href lines, vs high trailer.
    // ev_kind at line ev_line: 1 raise cap_en, 2 drop cap_en, 3 async reset.
    task automatic send_frame(input int nbytes, input int full_idx, input int ev_line, input int ev_kind);
        int         widx;
        int         p;
        logic [7:0] v;
        logic [7:0] pv;
        logic       fl;
        widx = 0;
        pv   = 8'd0;
        pclk_cycle(1'b0, 1'b0, 8'd0, 1'b0);
        pclk_cycle(1'b0, 1'b0, 8'd0, 1'b0);
        for (int l = 0; l < 4; l++) begin
            if (l == ev_line && ev_kind == 1) cap_en = 1'b1;
            if (l == ev_line && ev_kind == 2) cap_en = 1'b0;
            for (int b = 0; b < nbytes; b++) begin
                v  = 8'(l * nbytes + b);
                fl = 1'b0;
                if (l == ev_line && ev_kind == 3 && b == 2) do_reset();
                if (b % 2 == 1) begin
                    p = b / 2;
                    if (p >= 2 && p < 6 && l >= 1 && l < 3) begin
                        if (widx == full_idx) begin
                            fl = 1'b1;
                        end else if (exp_on) begin
                            q0.push_back({pv, v});
                            q1.push_back({pv, v});
                        end
                        widx++;
                    end
                end
                pclk_cycle(1'b0, 1'b1, v, fl);
                pv = v;
            end
            for (int k = 0; k < 3; k++) pclk_cycle(1'b0, 1'b0, 8'd0, 1'b0);
        end
        for (int k = 0; k < 3; k++) pclk_cycle(1'b1, 1'b0, 8'd0, 1'b0);
    endtask

    task automatic end_phase(input string nm, input int exp_wr, input int exp_fs, input int exp_fd, input logic exp_ovf);
        repeat (20) @(negedge clk);
        check($sformatf("%s_wr0", nm), 32'(wr_cnt0), 32'(exp_wr));
        check($sformatf("%s_wr1", nm), 32'(wr_cnt1), 32'(exp_wr));
        check($sformatf("%s_fs0", nm), 32'(fs_cnt0), 32'(exp_fs));
        check($sformatf("%s_fs1", nm), 32'(fs_cnt1), 32'(exp_fs));
        check($sformatf("%s_fd0", nm), 32'(fd_cnt0), 32'(exp_fd));
        check($sformatf("%s_fd1", nm), 32'(fd_cnt1), 32'(exp_fd));
        check($sformatf("%s_ovf0", nm), 32'(ovf0), 32'(exp_ovf));
        check($sformatf("%s_ovf1", nm), 32'(ovf1), 32'(exp_ovf));
        check($sformatf("%s_q0", nm), 32'(q0.size()), 32'd0);
        check($sformatf("%s_q1", nm), 32'(q1.size()), 32'd0);
        wr_cnt0 = 0; wr_cnt1 = 0;
        fs_cnt0 = 0; fs_cnt1 = 0;
        fd_cnt0 = 0; fd_cnt1 = 0;
        q0.delete();
        q1.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n    = 1'b0;
        cap_en   = 1'b0;
        vpclk    = 1'b0;
        vs_line  = 1'b0;
        vhref    = 1'b0;
        vdb      = 8'd0;
        wrf_full = 1'b0;
        err_clr  = 1'b0;
        exp_on   = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_wrreq0", 32'(wr0), 32'd0);
        check("reset_din0", 32'(din0), 32'd0);
        check("reset_fs0", 32'(fs0), 32'd0);
        check("reset_fd0", 32'(fd0), 32'd0);
        check("reset_ovf0", 32'(ovf0), 32'd0);
        check("reset_wrreq1", 32'(wr1), 32'd0);
        check("reset_ovf1", 32'(ovf1), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Base capture
        cap_en = 1'b1;
        exp_on = 1'b1;
        for (int k = 0; k < 3; k++) pclk_cycle(1'b1, 1'b0, 8'd0, 1'b0);
        send_frame(16, -1, -1, 0);
        check("base_first0", 32'(first0), 32'h1415);
        check("base_first1", 32'(first1), 32'h1415);
        end_phase("base", 8, 1, 1, 1'b0);

        // Back-pressure on the third window pixel
        send_frame(16, 2, -1, 0);
        end_phase("bp", 7, 1, 1, 1'b1);
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("bp_clr_ovf0", 32'(ovf0), 32'd0);
        check("bp_clr_ovf1", 32'(ovf1), 32'd0);

        // Frame gating
        cap_en = 1'b0;
        exp_on = 1'b0;
        send_frame(16, -1, 1, 1);
        end_phase("gate_a", 0, 0, 0, 1'b0);
        exp_on = 1'b1;
        send_frame(16, -1, 2, 2);
        end_phase("gate_b", 8, 1, 1, 1'b0);
        exp_on = 1'b0;
        send_frame(16, -1, -1, 0);
        end_phase("gate_c", 0, 0, 0, 1'b0);

        // Odd byte count per line
        cap_en = 1'b1;
        exp_on = 1'b1;
        send_frame(17, -1, -1, 0);
        check("partial_first0", 32'(first0), 32'h1516);
        end_phase("partial", 8, 1, 1, 1'b0);

        // Async reset in the middle of line 1
        exp_on = 1'b1;
        send_frame(16, -1, 1, 3);
        end_phase("rst", 0, 1, 0, 1'b0);
        exp_on = 1'b1;
        send_frame(16, -1, -1, 0);
        end_phase("post_rst", 8, 1, 1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
